// File: rtl/memory_arbiter.sv
// memory_arbiter: merges the CPU instruction and data memory ports onto one
// single-port external memory bus. Accesses are serialized through
// IDLE -> IBUS/DBUS -> RESP; bus outputs are registered and each completed
// access returns a one-cycle ready pulse on the side that was served.
// A watchdog ends a bus access the memory never acknowledges.
//
// Ports:
//   clock_i, reset_n_i            clock, synchronous active-low reset
//   imem_*                        instruction fetch request / data / ready
//   dmem_*                        data load/store request / data / ready
//   mem_*                         external memory bus (registered outputs)
//   timeout_o                     one-cycle pulse with ready on watchdog expiry
//
// Parameter TIMEOUT_CYCLES: bus cycles before forced termination (0 = off).
// Build option MEMORY_ARBITER_ROUND_ROBIN_EN: on contention grant the side
// not served last; otherwise data always beats instruction.
module memory_arbiter #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
) (
  input  logic        clock_i,
  input  logic        reset_n_i,
  input  logic [31:0] imem_address_i,
  input  logic        imem_read_i,
  output logic [31:0] imem_data_o,
  output logic        imem_data_ready_o,
  input  logic [31:0] dmem_address_i,
  input  logic [31:0] dmem_data_i,
  output logic [31:0] dmem_data_o,
  input  logic        dmem_read_i,
  input  logic        dmem_write_i,
  input  logic [3:0]  dmem_sel_i,
  output logic        dmem_data_ready_o,
  output logic [31:0] mem_address_o,
  output logic [31:0] mem_data_o,
  input  logic [31:0] mem_data_i,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic [3:0]  mem_sel_o,
  input  logic        mem_ack_i,
  output logic        timeout_o
);

  typedef enum logic [1:0] {IDLE, IBUS, DBUS, RESP} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] idata_q, idata_d;
  logic [31:0] ddata_q, ddata_d;
  logic        irdy_q, irdy_d;
  logic        drdy_q, drdy_d;
  logic        tmo_q, tmo_d;
  logic [15:0] wdog_q, wdog_d;

  logic ireq, dreq, grant_data;
  logic in_bus, ack_hit, wdog_hit, bus_done;

  assign ireq = imem_read_i;
  assign dreq = dmem_read_i | dmem_write_i;

`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
  // 1 = data side was granted last
  logic last_gnt_q, last_gnt_d;
  assign grant_data = dreq & (~ireq | ~last_gnt_q);
`else
  assign grant_data = dreq;
`endif

  assign in_bus   = (state_q == IBUS) || (state_q == DBUS);
  assign ack_hit  = in_bus & mem_ack_i;
  // Count reaches TIMEOUT_CYCLES at the end of this bus cycle; ack takes precedence.
  assign wdog_hit = in_bus & ~mem_ack_i & (TIMEOUT_CYCLES != 16'd0) &
                    (({1'b0, wdog_q} + 17'd1) == {1'b0, TIMEOUT_CYCLES});
  assign bus_done = ack_hit | wdog_hit;

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      sel_q   <= '0;
      idata_q <= '0;
      ddata_q <= '0;
      irdy_q  <= 1'b0;
      drdy_q  <= 1'b0;
      tmo_q   <= 1'b0;
      wdog_q  <= '0;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
      last_gnt_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      sel_q   <= sel_d;
      idata_q <= idata_d;
      ddata_q <= ddata_d;
      irdy_q  <= irdy_d;
      drdy_q  <= drdy_d;
      tmo_q   <= tmo_d;
      wdog_q  <= wdog_d;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
      last_gnt_q <= last_gnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (ireq | dreq) state_d = grant_data ? DBUS : IBUS;
      IBUS, DBUS: if (bus_done) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values for the registered outputs.
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    sel_d   = sel_q;
    idata_d = idata_q;
    ddata_d = ddata_q;
    irdy_d  = 1'b0;
    drdy_d  = 1'b0;
    tmo_d   = 1'b0;
    wdog_d  = wdog_q;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
    last_gnt_d = last_gnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        wdog_d = '0;
        if (ireq | dreq) begin
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
          last_gnt_d = grant_data;
`endif
          if (grant_data) begin
            addr_d  = dmem_address_i;
            wdata_d = dmem_data_i;
            sel_d   = dmem_sel_i;
            wr_d    = dmem_write_i;
            rd_d    = ~dmem_write_i;
          end else begin
            addr_d  = imem_address_i;
            wdata_d = '0;
            sel_d   = '1;
            wr_d    = 1'b0;
            rd_d    = 1'b1;
          end
        end
      end
      IBUS, DBUS: begin
        wdog_d = wdog_q + 16'd1;
        if (bus_done) begin
          rd_d   = 1'b0;
          wr_d   = 1'b0;
          tmo_d  = wdog_hit;
          irdy_d = (state_q == IBUS);
          drdy_d = (state_q == DBUS);
          if (state_q == IBUS)
            idata_d = ack_hit ? mem_data_i : '1;
          else if (!wr_q)
            ddata_d = ack_hit ? mem_data_i : '1;
        end
      end
      default: ;
    endcase
  end

  assign mem_address_o     = addr_q;
  assign mem_data_o        = wdata_q;
  assign mem_read_o        = rd_q;
  assign mem_write_o       = wr_q;
  assign mem_sel_o         = sel_q;
  assign imem_data_o       = idata_q;
  assign dmem_data_o       = ddata_q;
  assign imem_data_ready_o = irdy_q;
  assign dmem_data_ready_o = drdy_q;
  assign timeout_o         = tmo_q;

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Sits directly downstream of the CPU pipeline's instruction and data memory ports and merges them onto one external single-port memory bus. Each side sees its own request/ready handshake. The arbiter serializes accesses, registers bus outputs, and returns read data with a one-cycle ready pulse. A watchdog counter terminates accesses that the memory never acknowledges.

## Interface
- TIMEOUT_CYCLES, 16'd1024: maximum cycles in a bus state before forced termination; 0 disables the watchdog.

- clock_i  input  1  system clock, all logic on rising edge
- reset_n_i  input  1  synchronous, active-low reset
- imem_address_i  input  32  instruction fetch address
- imem_read_i  input  1  instruction fetch request (level, held until ready)
- imem_data_o  output  32  fetched instruction word
- imem_data_ready_o  output  1  one-cycle pulse: imem_data_o valid
- dmem_address_i  input  32  data address
- dmem_data_i  input  32  store data
- dmem_data_o  output  32  load data
- dmem_read_i  input  1  load request (level)
- dmem_write_i  input  1  store request (level)
- dmem_sel_i  input  4  byte lane enables
- dmem_data_ready_o  output  1  one-cycle pulse: load/store complete
- mem_address_o  output  32  bus address
- mem_data_o  output  32  bus write data
- mem_data_i  input  32  bus read data
- mem_read_o  output  1  bus read strobe
- mem_write_o  output  1  bus write strobe
- mem_sel_o  output  4  bus byte enables
- mem_ack_i  input  1  bus acknowledge; mem_data_i valid in the same cycle for reads
- timeout_o  output  1  one-cycle pulse: watchdog terminated an access

## Operation
- States: IDLE, IBUS, DBUS, RESP.
- IDLE: sample requests. A data request is dmem_read_i|dmem_write_i. Selection follows the arbitration rule (see Configuration). Latch address/data/sel/direction into bus registers and go to IBUS or DBUS. With no request, stay in IDLE.
- IBUS: mem_read_o=1, mem_sel_o=4'b1111, mem_write_o=0.
- DBUS: mem_write_o=dmem_write_i (latched), mem_read_o=!mem_write_o. Store wins if read and write are both asserted. mem_sel_o=dmem_sel_i (latched).
- In IBUS/DBUS, mem_ack_i=1 causes:
  - mem_data_i to be captured into imem_data_o or dmem_data_o (reads only; a store leaves dmem_data_o unchanged);
  - all bus strobes to drop;
  - the next state to be RESP.
- RESP: the granted side's ready output is 1 for exactly this cycle. Requests are ignored. Next state is IDLE, so a requester may change its address after ready without re-triggering the old access.
- Watchdog: a 16-bit counter clears on entry to IBUS/DBUS and increments each bus cycle. When it reaches TIMEOUT_CYCLES without an ack, the arbiter:
  - drops the strobes;
  - loads the data output with 32'hFFFF_FFFF for a read;
  - pulses timeout_o together with ready in RESP.
- mem_ack_i in IDLE or RESP is ignored.
- Request inputs are sampled only in IDLE. Changes while an access is in flight do not affect the bus.

## Timing
- Reset (reset_n_i low at an edge) puts the arbiter in IDLE and clears every output to 0 (data outputs 32'h0, strobes, ready, timeout_o). The watchdog counter and last-grant register also clear (last grant = instruction). An in-flight access is abandoned; an ack arriving afterwards is ignored.
- Request visible in IDLE at edge t0 → bus strobes asserted in cycle t0+1.
- Ack sampled at the end of cycle k → ready pulse in cycle k+1 → IDLE in cycle k+2.
- Zero-wait memory gives 2 cycles of latency from request to ready and one access per 3 cycles.
- Bus outputs are registered and stable for the whole IBUS/DBUS period.
- imem_data_o and dmem_data_o hold their value until the next completing access of the same side.

## Configuration
- MEMORY_ARBITER_ROUND_ROBIN_EN defined: when both sides request in IDLE, grant the side not served last. A 1-bit last-grant register updates on each grant.
- Undefined: fixed priority, data always beats instruction. The last-grant register is not built.
- A single request is granted immediately in either build.

## Test plan
- Instruction only: imem_read_i=1, addr 0x100, ack on the first bus cycle with data 0x12345678 → mem_read_o high 1 cycle, imem_data_ready_o in cycle 3, imem_data_o=0x12345678.
- Store: dmem_write_i=1, addr 0x2000, data 0xCAFEBABE, sel 4'b0011, ack after 3 wait cycles → mem_write_o held 4 cycles with sel 0011, dmem_data_ready_o pulse, dmem_data_o unchanged.
- Contention with both requests held for 3 accesses → with the macro, D, I, D order; without it, D, D, D while imem_data_ready_o stays 0.
- Watchdog: TIMEOUT_CYCLES=8, no ack on a load → strobes drop after 8 bus cycles, dmem_data_o=0xFFFFFFFF, timeout_o and dmem_data_ready_o pulse together.
- Reset in DBUS, then ack one cycle later → all outputs 0, no ready pulse, state IDLE.
- Spurious mem_ack_i in IDLE with no requests → no ready, no strobe, outputs unchanged.
